// File: rtl/sdmac_pkg.sv
// Shared SDMAC definitions: DMA counter state encoding, halt cause codes
// and the bus port-size decode used by the address generator.
package sdmac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_AS,
    WAIT_ACK,
    WAIT_END,
    HALT
  } dma_state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_BERR = 2'b01;
  localparam logic [1:0] ERR_WRAP = 2'b10;
  localparam logic [1:0] ERR_SIZE = 2'b11;

  typedef enum logic [1:0] {
    P_NONE,
    P32,
    P16,
    P8
  } port_size_e;

  // STERM_ or both DSACKs means a 32-bit port; a lone DSACK1_ is 16-bit,
  // a lone DSACK0_ is 8-bit. All inputs are active low.
  function automatic port_size_e decode_port(input logic sterm_n,
                                             input logic dsack1_n,
                                             input logic dsack0_n);
    port_size_e size;
    size = P_NONE;
    if (!sterm_n || (!dsack1_n && !dsack0_n)) begin
      size = P32;
    end else if (!dsack1_n) begin
      size = P16;
    end else if (!dsack0_n) begin
      size = P8;
    end
    return size;
  endfunction

endpackage

// File: rtl/sync_bus_in.sv
// Multi-stage synchroniser for a vector of active-low bus strobes.
// Flops reset to 1 so every strobe reads as inactive coming out of reset.
module sync_bus_in #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  localparam int NSTG = (STAGES < 1) ? 1 : STAGES;

  logic [WIDTH-1:0] stage [NSTG];

  // Shift the raw strobes through the flop chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSTG; i++) begin
        stage[i] <= '1;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < NSTG; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[NSTG-1];

endmodule

// File: rtl/dma_addr_gen.sv
// DMA address counter: loaded by the CPU, drives the 68030 address bus
// while the SDMAC owns it and advances by the acknowledged port width
// once per bus cycle. Bus errors, wrap-around and 8-bit ports halt it.
module dma_addr_gen
  import sdmac_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              nCLK,
  input  logic              RST,
  input  logic              ACR_WR,
  input  logic [ADDR_W-1:0] MID,
  input  logic              OWN_,
  input  logic              AS_,
  input  logic              DSACK0_,
  input  logic              DSACK1_,
  input  logic              STERM_,
  input  logic              BERR_,
  output logic [ADDR_W-1:0] ADDR_O,
  output logic              ADDR_OE,
  output logic              A1,
  output logic              CYC_DONE,
  output logic              HALTED,
  output logic [1:0]        ERR_CODE
);

  logic [4:0] raw_bus;
  logic [4:0] sync_bus;
  logic       as_s;
  logic       dsack0_s;
  logic       dsack1_s;
  logic       sterm_s;
  logic       berr_s;

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              halted_q, halted_d;
  logic [1:0]        err_q, err_d;
  logic              cyc_done_q, cyc_done_d;
  logic              oe_q, oe_d;

  port_size_e        port;
  logic [ADDR_W-1:0] inc;
  logic [ADDR_W:0]   sum;

  assign raw_bus = {BERR_, STERM_, DSACK1_, DSACK0_, AS_};

  sync_bus_in #(
    .WIDTH (5),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(nCLK),
    .rst(RST),
    .d  (raw_bus),
    .q  (sync_bus)
  );

  assign as_s     = sync_bus[0];
  assign dsack0_s = sync_bus[1];
  assign dsack1_s = sync_bus[2];
  assign sterm_s  = sync_bus[3];
  assign berr_s   = sync_bus[4];

  // A 32-bit port moves a longword unless the address is only word
  // aligned (A1 set), in which case it moves just the upper word.
  assign port = decode_port(sterm_s, dsack1_s, dsack0_s);
  assign inc  = (port == P32 && !addr_q[1]) ? ADDR_W'(4) : ADDR_W'(2);
  assign sum  = {1'b0, addr_q} + {1'b0, inc};

  // Next-state, counter update and error capture; a CPU load overrides all.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    halted_d   = halted_q;
    err_d      = err_q;
    cyc_done_d = 1'b0;

    if (ACR_WR) begin
      addr_d   = {MID[ADDR_W-1:1], 1'b0};
      halted_d = 1'b0;
      err_d    = ERR_NONE;
      state_d  = IDLE;
    end else if (OWN_ && state_q != HALT) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!halted_q) begin
            state_d = WAIT_AS;
          end
        end
        WAIT_AS: begin
          if (!as_s) begin
            state_d = WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (!berr_s) begin
            state_d  = HALT;
            halted_d = 1'b1;
            err_d    = ERR_BERR;
          end else begin
            case (port)
              P32, P16: begin
                addr_d     = sum[ADDR_W-1:0];
                cyc_done_d = 1'b1;
                if (sum[ADDR_W]) begin
                  state_d  = HALT;
                  halted_d = 1'b1;
                  err_d    = ERR_WRAP;
                end else begin
                  state_d = WAIT_END;
                end
              end
              P8: begin
                state_d  = HALT;
                halted_d = 1'b1;
                err_d    = ERR_SIZE;
              end
              default: begin
              end
            endcase
          end
        end
        WAIT_END: begin
          if (as_s) begin
            state_d = WAIT_AS;
          end
        end
        HALT: begin
          halted_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Drivers are enabled from the upcoming halt flag so the bus is
  // released on the same edge that halts the counter.
  assign oe_d = ~OWN_ & ~halted_d;

  // State, counter and output registers.
  always_ff @(posedge nCLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      halted_q   <= 1'b0;
      err_q      <= ERR_NONE;
      cyc_done_q <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      halted_q   <= halted_d;
      err_q      <= err_d;
      cyc_done_q <= cyc_done_d;
      oe_q       <= oe_d;
    end
  end

  assign ADDR_O   = addr_q;
  assign ADDR_OE  = oe_q;
  assign A1       = addr_q[1];
  assign CYC_DONE = cyc_done_q;
  assign HALTED   = halted_q;
  assign ERR_CODE = err_q;

endmodule

// File: tb/tb_dma_addr_gen.sv
// Directed bench for dma_addr_gen: loads, 32/16-bit cycles, BERR, wrap,
// size error, load priority, bus release and asynchronous reset.
module tb_dma_addr_gen;

  logic        nCLK;
  logic        RST;
  logic        ACR_WR;
  logic [31:0] MID;
  logic        OWN_;
  logic        AS_;
  logic        DSACK0_;
  logic        DSACK1_;
  logic        STERM_;
  logic        BERR_;
  logic [31:0] ADDR_O;
  logic        ADDR_OE;
  logic        A1;
  logic        CYC_DONE;
  logic        HALTED;
  logic [1:0]  ERR_CODE;

  int checkCount;
  int passCount;
  int pulses;

  dma_addr_gen #(
    .ADDR_W     (32),
    .SYNC_STAGES(2)
  ) dut (
    .nCLK    (nCLK),
    .RST     (RST),
    .ACR_WR  (ACR_WR),
    .MID     (MID),
    .OWN_    (OWN_),
    .AS_     (AS_),
    .DSACK0_ (DSACK0_),
    .DSACK1_ (DSACK1_),
    .STERM_  (STERM_),
    .BERR_   (BERR_),
    .ADDR_O  (ADDR_O),
    .ADDR_OE (ADDR_OE),
    .A1      (A1),
    .CYC_DONE(CYC_DONE),
    .HALTED  (HALTED),
    .ERR_CODE(ERR_CODE)
  );

  // Free-running 100 MHz block clock.
  initial begin
    nCLK = 1'b0;
    forever #5 nCLK = ~nCLK;
  end

  // Compare one observed value with its expected value and tally it.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge nCLK);
    #1;
  endtask

  // CPU write of a new start address.
  task automatic loadAddr(input logic [31:0] value);
    ACR_WR = 1'b1;
    MID    = value;
    tick(1);
    ACR_WR = 1'b0;
    MID    = '0;
  endtask

  // One bus cycle: assert AS_ with the given termination, count CYC_DONE
  // pulses over a fixed window, then release the bus and let it settle.
  task automatic applyStimulus(input logic d0, input logic d1,
                               input logic st, input logic be,
                               output int nPulse);
    nPulse  = 0;
    AS_     = 1'b0;
    DSACK0_ = d0;
    DSACK1_ = d1;
    STERM_  = st;
    BERR_   = be;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (CYC_DONE) nPulse++;
    end
    AS_     = 1'b1;
    DSACK0_ = 1'b1;
    DSACK1_ = 1'b1;
    STERM_  = 1'b1;
    BERR_   = 1'b1;
    tick(5);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    RST     = 1'b1;
    ACR_WR  = 1'b0;
    MID     = '0;
    OWN_    = 1'b1;
    AS_     = 1'b1;
    DSACK0_ = 1'b1;
    DSACK1_ = 1'b1;
    STERM_  = 1'b1;
    BERR_   = 1'b1;

    tick(2);
    checkOutput("rst_addr", ADDR_O, 32'h0);
    checkOutput("rst_oe", {31'b0, ADDR_OE}, 32'h0);
    checkOutput("rst_halted", {31'b0, HALTED}, 32'h0);
    checkOutput("rst_err", {30'b0, ERR_CODE}, 32'h0);
    checkOutput("rst_cyc", {31'b0, CYC_DONE}, 32'h0);
    RST = 1'b0;
    tick(1);

    $display("[TB] load and 32-bit cycles");
    OWN_ = 1'b0;
    loadAddr(32'h0010_0000);
    checkOutput("load_addr", ADDR_O, 32'h0010_0000);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, pulses);
      checkOutput("p32_addr", ADDR_O, 32'h0010_0000 + 32'(4 * i));
      checkOutput("p32_pulse", 32'(pulses), 32'd1);
    end
    checkOutput("p32_oe", {31'b0, ADDR_OE}, 32'h1);
    checkOutput("p32_a1", {31'b0, A1}, 32'h0);

    $display("[TB] bus released while waiting for acknowledge");
    AS_ = 1'b0; DSACK0_ = 1'b0; DSACK1_ = 1'b0;
    tick(3);
    OWN_   = 1'b1;
    pulses = 0;
    tick(1);
    if (CYC_DONE) pulses++;
    AS_ = 1'b1; DSACK0_ = 1'b1; DSACK1_ = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (CYC_DONE) pulses++;
    end
    checkOutput("own_addr", ADDR_O, 32'h0010_000C);
    checkOutput("own_pulse", 32'(pulses), 32'd0);
    checkOutput("own_oe", {31'b0, ADDR_OE}, 32'h0);
    OWN_ = 1'b0;
    tick(1);

    $display("[TB] 16-bit port and misalignment");
    loadAddr(32'h0020_0003);
    checkOutput("mis_addr", ADDR_O, 32'h0020_0002);
    checkOutput("mis_a1", {31'b0, A1}, 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, pulses);
    checkOutput("mis32_addr", ADDR_O, 32'h0020_0004);
    checkOutput("mis32_a1", {31'b0, A1}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, pulses);
    checkOutput("p16_addr", ADDR_O, 32'h0020_0006);
    checkOutput("p16_a1", {31'b0, A1}, 32'h1);
    checkOutput("p16_pulse", 32'(pulses), 32'd1);

    $display("[TB] bus error");
    loadAddr(32'h0000_1000);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, pulses);
    checkOutput("berr_halted", {31'b0, HALTED}, 32'h1);
    checkOutput("berr_err", {30'b0, ERR_CODE}, 32'h1);
    checkOutput("berr_addr", ADDR_O, 32'h0000_1000);
    checkOutput("berr_oe", {31'b0, ADDR_OE}, 32'h0);
    checkOutput("berr_pulse", 32'(pulses), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, pulses);
    checkOutput("halt_hold_addr", ADDR_O, 32'h0000_1000);
    checkOutput("halt_hold_pulse", 32'(pulses), 32'd0);
    loadAddr(32'h0000_2000);
    checkOutput("clr_halted", {31'b0, HALTED}, 32'h0);
    checkOutput("clr_err", {30'b0, ERR_CODE}, 32'h0);
    checkOutput("clr_addr", ADDR_O, 32'h0000_2000);
    checkOutput("clr_oe", {31'b0, ADDR_OE}, 32'h1);

    $display("[TB] wrap and size error");
    loadAddr(32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, pulses);
    checkOutput("wrap_addr", ADDR_O, 32'h0);
    checkOutput("wrap_halted", {31'b0, HALTED}, 32'h1);
    checkOutput("wrap_err", {30'b0, ERR_CODE}, 32'h2);
    checkOutput("wrap_oe", {31'b0, ADDR_OE}, 32'h0);
    loadAddr(32'h0000_4000);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, pulses);
    checkOutput("size_err", {30'b0, ERR_CODE}, 32'h3);
    checkOutput("size_addr", ADDR_O, 32'h0000_4000);
    checkOutput("size_halted", {31'b0, HALTED}, 32'h1);
    checkOutput("size_pulse", 32'(pulses), 32'd0);

    $display("[TB] load priority over acknowledge");
    loadAddr(32'h0000_5000);
    AS_ = 1'b0; DSACK0_ = 1'b0; DSACK1_ = 1'b0;
    tick(3);
    ACR_WR = 1'b1;
    MID    = 32'h0000_3000;
    tick(1);
    ACR_WR = 1'b0;
    MID    = '0;
    checkOutput("prio_addr", ADDR_O, 32'h0000_3000);
    checkOutput("prio_cyc", {31'b0, CYC_DONE}, 32'h0);
    AS_ = 1'b1; DSACK0_ = 1'b1; DSACK1_ = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (CYC_DONE) pulses++;
    end
    checkOutput("prio_pulse", 32'(pulses), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, pulses);
    checkOutput("prio_next_addr", ADDR_O, 32'h0000_3004);
    checkOutput("prio_next_pulse", 32'(pulses), 32'd1);

    $display("[TB] asynchronous reset during acknowledge wait");
    loadAddr(32'h0000_6000);
    AS_ = 1'b0; DSACK0_ = 1'b0; DSACK1_ = 1'b0;
    tick(3);
    RST = 1'b1;
    #2;
    checkOutput("arst_addr", ADDR_O, 32'h0);
    checkOutput("arst_oe", {31'b0, ADDR_OE}, 32'h0);
    checkOutput("arst_halted", {31'b0, HALTED}, 32'h0);
    checkOutput("arst_err", {30'b0, ERR_CODE}, 32'h0);
    checkOutput("arst_cyc", {31'b0, CYC_DONE}, 32'h0);
    AS_ = 1'b1; DSACK0_ = 1'b1; DSACK1_ = 1'b1;
    tick(2);
    RST = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (CYC_DONE) pulses++;
    end
    checkOutput("post_rst_addr", ADDR_O, 32'h0);
    checkOutput("post_rst_pulse", 32'(pulses), 32'd0);
    checkOutput("post_rst_oe", {31'b0, ADDR_OE}, 32'h1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/dma_addr_gen.md
Name: dma_addr_gen

Overview:
- DMA address counter (ACR engine) downstream of the SDMAC core.
- The CPU loads the start address through an ACR write. While the SDMAC owns the bus, the block drives the 68030 address bus.
- It advances the address by the byte count acknowledged on each completed bus cycle and supplies A1 back to the CPU-side state machine.
- Replaces the external Ramsey address generator that is enabled by _DMAEN.

Parameters:
- ADDR_W, 32, address counter width in bits.
- SYNC_STAGES, 2, synchroniser flops on AS_, DSACK0_, DSACK1_, STERM_ and BERR_ (minimum 1).

Ports:
- nCLK  input  1  block clock, rising edge active.
- RST  input  1  asynchronous active-high reset.
- ACR_WR  input  1  one-cycle load strobe from the register file.
- MID  input  ADDR_W  CPU write data carrying the new address.
- OWN_  input  1  low while the SDMAC is bus master.
- AS_  input  1  bus address strobe, asynchronous.
- DSACK0_  input  1  data acknowledge bit 0, asynchronous, active low.
- DSACK1_  input  1  data acknowledge bit 1, asynchronous, active low.
- STERM_  input  1  synchronous termination, active low.
- BERR_  input  1  bus error, active low.
- ADDR_O  output  ADDR_W  current DMA address.
- ADDR_OE  output  1  enables the address bus drivers.
- A1  output  1  equals ADDR_O[1], fed to the CPU state machine.
- CYC_DONE  output  1  one-cycle pulse per accepted transfer.
- HALTED  output  1  sticky flag: BERR, wrap or size error seen.
- ERR_CODE  output  2  cause of HALTED: 00 none, 01 BERR, 10 wrap, 11 size.

Behaviour:
Reset (RST high, asynchronous):
- ADDR_O=0, ADDR_OE=0, CYC_DONE=0, HALTED=0, ERR_CODE=00.
- State=IDLE.

Load:
- On ACR_WR, ADDR_O <= {MID[ADDR_W-1:1],1'b0}; bit 0 is always forced to 0.
- HALTED and ERR_CODE clear.
- State returns to IDLE.
- ACR_WR has priority over any same-cycle increment or state transition.

Input synchronisation:
- AS_, DSACK0_, DSACK1_, STERM_ and BERR_ pass through SYNC_STAGES flops. All decisions below use the synchronised values.
- OWN_ and ACR_WR are already synchronous to nCLK.

ADDR_OE:
- Registered. Equals ~OWN_ & ~HALTED, updated one cycle after OWN_ changes.

State machine:
- IDLE: go to WAIT_AS when OWN_=0 and HALTED=0.
- WAIT_AS: go to WAIT_ACK when AS_=0.
- WAIT_ACK:
  - BERR_=0: go to HALT, ERR_CODE=01, no increment. BERR has priority over any acknowledge in the same cycle.
  - STERM_=0, or both DSACKs low (32-bit port): increment = 4 if A1=0, else 2.
  - DSACK1_ low only (16-bit port): increment = 2.
  - DSACK0_ low only (8-bit port): go to HALT, ERR_CODE=11, no increment.
  - After a valid acknowledge: apply the increment to ADDR_O, pulse CYC_DONE for 1 cycle, go to WAIT_END.
- WAIT_END: go to WAIT_AS when AS_=1. Exactly one increment is made per AS_ assertion.
- HALT: hold ADDR_O and keep HALTED=1. Leave only on ACR_WR or RST.

Arithmetic:
- The increment is unsigned modulo 2^ADDR_W.
- Carry out of bit ADDR_W-1: ADDR_O is still updated (wraps), then go to HALT with ERR_CODE=10.
- Example: 0xFFFFFFFC + 4 gives ADDR_O=0x00000000, HALTED=1.

OWN_ rising (bus released):
- From any state except HALT, go to IDLE.
- No increment if the acknowledge was not yet sampled.
- An increment already applied is kept.

Latency:
- ADDR_O updates on the same edge as the state change out of WAIT_ACK, i.e. SYNC_STAGES+1 edges after the raw acknowledge edge.

Decomposition:
- Shared package (sdmac_pkg):
  - State encoding enum (IDLE, WAIT_AS, WAIT_ACK, WAIT_END, HALT).
  - ERR_CODE constants.
  - Port-size decode constants (P32, P16, P8).
- One sub-module: sync_bus_in. It is a parameterised SYNC_STAGES synchroniser vector, reset to 1 (inactive), also reused by CPU_SM.
- The counter and state machine stay in dma_addr_gen.

Test Plan:
- Load and 32-bit cycles: ACR_WR with MID=0x00100000, OWN_=0, three AS_/DSACK0_+DSACK1_ cycles → ADDR_O 0x00100004, 0x00100008, 0x0010000C, three CYC_DONE pulses, ADDR_OE=1.
- 16-bit port and misalignment: load 0x00200002, a 32-bit ack gives 0x00200004 (+2 because A1=1), then DSACK1_ only gives 0x00200006; A1 tracks bit 1 each time.
- BERR: load 0x1000, BERR_ and DSACK both low in WAIT_ACK → HALTED=1, ERR_CODE=01, ADDR_O=0x1000, ADDR_OE=0; a following ACR_WR of 0x2000 clears HALTED.
- Wrap and size error: load 0xFFFFFFFC, STERM_ ack → ADDR_O=0, ERR_CODE=10. Separately, a DSACK0_-only ack → ERR_CODE=11 with no increment.
- Priority and reset: ACR_WR of 0x3000 on the same cycle as an ack → ADDR_O=0x3000 with no CYC_DONE. RST pulse during WAIT_ACK → all outputs 0 immediately (asynchronous), and no increment after release.
